// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between the fetch and data ports, data port first.
// Define ARB_PERF_CNT_EN to build the stall and grant performance counters.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic [31:0]       inst_rdata,
   output logic              inst_valid,
   input  logic              data_req,
   input  logic [3:0]        data_wen,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [31:0]       data_wdata,
   output logic [31:0]       data_rdata,
   output logic              data_valid,
   output logic              bus_req,
   output logic [3:0]        bus_wen,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [31:0]       bus_wdata,
   input  logic [31:0]       bus_rdata,
   input  logic              bus_ack,
   output logic              stall,
   output logic              bus_err,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_grant_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY_I,
      S_BUSY_D
   } state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t            r_state;
   logic [15:0]       r_tcnt;
   logic              r_bus_req;
   logic [3:0]        r_bus_wen;
   logic [ADDR_W-1:0] r_bus_addr;
   logic [31:0]       r_bus_wdata;
   logic [31:0]       r_inst_rdata;
   logic [31:0]       r_data_rdata;
   logic              r_inst_valid;
   logic              r_data_valid;
   logic              r_bus_err;

   logic              w_inst_pend;
   logic              w_data_pend;
   logic              w_tmo;
   logic              w_done;
   logic [31:0]       w_ret;

   // A port whose valid is high this cycle is finishing, not requesting.
   assign w_inst_pend = inst_req & ~r_inst_valid;
   assign w_data_pend = data_req & ~r_data_valid;
   assign w_tmo       = (r_tcnt == TO_LAST);
   assign w_done      = bus_ack | w_tmo;
   assign w_ret       = bus_ack ? bus_rdata : 32'h0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_tcnt       <= '0;
         r_bus_req    <= 1'b0;
         r_bus_wen    <= '0;
         r_bus_addr   <= '0;
         r_bus_wdata  <= '0;
         r_inst_rdata <= '0;
         r_data_rdata <= '0;
         r_inst_valid <= 1'b0;
         r_data_valid <= 1'b0;
         r_bus_err    <= 1'b0;
      end else begin
         r_inst_valid <= 1'b0;
         r_data_valid <= 1'b0;
         r_bus_err    <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_data_pend) begin
                  r_state     <= S_BUSY_D;
                  r_bus_req   <= 1'b1;
                  r_bus_wen   <= data_wen;
                  r_bus_addr  <= data_addr;
                  r_bus_wdata <= data_wdata;
                  r_tcnt      <= '0;
               end else if (w_inst_pend) begin
                  r_state     <= S_BUSY_I;
                  r_bus_req   <= 1'b1;
                  r_bus_wen   <= '0;
                  r_bus_addr  <= inst_addr;
                  r_bus_wdata <= '0;
                  r_tcnt      <= '0;
               end
            end
            S_BUSY_I, S_BUSY_D: begin
               if (w_done) begin
                  r_state   <= S_IDLE;
                  r_bus_req <= 1'b0;
                  // An ack in the timeout cycle still completes normally.
                  r_bus_err <= ~bus_ack;
                  if (r_state == S_BUSY_I) begin
                     r_inst_rdata <= w_ret;
                     r_inst_valid <= 1'b1;
                  end else begin
                     r_data_rdata <= w_ret;
                     r_data_valid <= 1'b1;
                  end
               end else begin
                  r_tcnt <= r_tcnt + 16'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign inst_rdata = r_inst_rdata;
   assign inst_valid = r_inst_valid;
   assign data_rdata = r_data_rdata;
   assign data_valid = r_data_valid;
   assign bus_req    = r_bus_req;
   assign bus_wen    = r_bus_wen;
   assign bus_addr   = r_bus_addr;
   assign bus_wdata  = r_bus_wdata;
   assign bus_err    = r_bus_err;
   assign stall      = w_inst_pend | w_data_pend;

`ifdef ARB_PERF_CNT_EN
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_grant;
   logic        w_grant;

   assign w_grant = (r_state == S_IDLE) & (w_inst_pend | w_data_pend);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_perf_stall <= '0;
         r_perf_grant <= '0;
      end else begin
         if (stall)   r_perf_stall <= r_perf_stall + 32'd1;
         if (w_grant) r_perf_grant <= r_perf_grant + 32'd1;
      end
   end

   assign perf_stall_cnt = r_perf_stall;
   assign perf_grant_cnt = r_perf_grant;
`else
   assign perf_stall_cnt = 32'h0;
   assign perf_grant_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a four-cycle timeout.
// Expected values are hand-derived cycle by cycle from the request edge.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic        inst_valid;
   logic        data_req;
   logic [3:0]  data_wen;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_valid;
   logic        bus_req;
   logic [3:0]  bus_wen;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic        stall;
   logic        bus_err;
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_grant_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] g0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .TIMEOUT_CYCLES(4),
      .ADDR_W        (32)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .inst_req      (inst_req),
      .inst_addr     (inst_addr),
      .inst_rdata    (inst_rdata),
      .inst_valid    (inst_valid),
      .data_req      (data_req),
      .data_wen      (data_wen),
      .data_addr     (data_addr),
      .data_wdata    (data_wdata),
      .data_rdata    (data_rdata),
      .data_valid    (data_valid),
      .bus_req       (bus_req),
      .bus_wen       (bus_wen),
      .bus_addr      (bus_addr),
      .bus_wdata     (bus_wdata),
      .bus_rdata     (bus_rdata),
      .bus_ack       (bus_ack),
      .stall         (stall),
      .bus_err       (bus_err),
      .perf_stall_cnt(perf_stall_cnt),
      .perf_grant_cnt(perf_grant_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h want %08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst        = 1'b0;
      inst_req   = 1'b0;
      inst_addr  = '0;
      data_req   = 1'b0;
      data_wen   = '0;
      data_addr  = '0;
      data_wdata = '0;
      bus_rdata  = '0;
      bus_ack    = 1'b0;
      #1;
      chk("rst bus_req", 32'(bus_req), 0);
      chk("rst bus_addr", bus_addr, 0);
      chk("rst valids", 32'({inst_valid, data_valid}), 0);
      chk("rst bus_err", 32'(bus_err), 0);
      chk("rst perf", perf_grant_cnt | perf_stall_cnt, 0);
      tick();
      tick();
      rst = 1'b1;
      tick();

      // Fetch read with two wait cycles
      inst_req  = 1'b1;
      inst_addr = 32'hBFC0_0000;
      #1;
      chk("f stall0", 32'(stall), 1);
      chk("f req0", 32'(bus_req), 0);
      tick();
      chk("f req1", 32'(bus_req), 1);
      chk("f addr", bus_addr, 32'hBFC0_0000);
      chk("f wen", 32'(bus_wen), 0);
      tick();
      chk("f req2", 32'(bus_req), 1);
      tick();
      bus_ack   = 1'b1;
      bus_rdata = 32'h2408_0001;
      chk("f noval3", 32'(inst_valid), 0);
      chk("f stall3", 32'(stall), 1);
      tick();
      bus_ack = 1'b0;
      chk("f valid4", 32'(inst_valid), 1);
      chk("f rdata", inst_rdata, 32'h2408_0001);
      chk("f req4", 32'(bus_req), 0);
      chk("f stall4", 32'(stall), 0);
      inst_req = 1'b0;
      tick();
      chk("f valid5", 32'(inst_valid), 0);
      chk("f req5", 32'(bus_req), 0);

      // Collision: data first, fetch granted on the valid cycle
      inst_req   = 1'b1;
      inst_addr  = 32'hBFC0_0004;
      data_req   = 1'b1;
      data_wen   = 4'b0011;
      data_addr  = 32'h8000_1000;
      data_wdata = 32'h0000_BEEF;
      tick();
      chk("c req", 32'(bus_req), 1);
      chk("c wen", 32'(bus_wen), 32'h3);
      chk("c addr", bus_addr, 32'h8000_1000);
      chk("c wdata", bus_wdata, 32'h0000_BEEF);
      bus_ack   = 1'b1;
      bus_rdata = 32'h0;
      tick();
      bus_ack = 1'b0;
      chk("c dvalid", 32'(data_valid), 1);
      chk("c ivalid", 32'(inst_valid), 0);
      chk("c idle", 32'(bus_req), 0);
      chk("c stall", 32'(stall), 1);
      data_req = 1'b0;
      tick();
      chk("c freq", 32'(bus_req), 1);
      chk("c faddr", bus_addr, 32'hBFC0_0004);
      chk("c fwen", 32'(bus_wen), 0);
      chk("c fwdata", bus_wdata, 0);
      chk("c dvalid1", 32'(data_valid), 0);
      bus_ack   = 1'b1;
      bus_rdata = 32'hAAAA_5555;
      tick();
      bus_ack = 1'b0;
      chk("c fvalid", 32'(inst_valid), 1);
      chk("c frdata", inst_rdata, 32'hAAAA_5555);
      inst_req = 1'b0;
      tick();

      // Held request: data_req still high in its valid cycle
      g0        = perf_grant_cnt;
      data_req  = 1'b1;
      data_wen  = 4'b0000;
      data_addr = 32'h8000_0000;
      tick();
      bus_ack   = 1'b1;
      bus_rdata = 32'hCAFE_F00D;
      tick();
      bus_ack = 1'b0;
      chk("h valid", 32'(data_valid), 1);
      chk("h rdata", data_rdata, 32'hCAFE_F00D);
      tick();
      data_req = 1'b0;
      chk("h noregrant", 32'(bus_req), 0);
      chk("h valid1", 32'(data_valid), 0);
`ifdef ARB_PERF_CNT_EN
      chk("h grants", perf_grant_cnt - g0, 1);
`else
      chk("h grants", perf_grant_cnt, 0);
`endif
      tick();

      // Timeout on data with a fetch pending behind it
      data_req  = 1'b1;
      data_addr = 32'h8000_0010;
      inst_req  = 1'b1;
      inst_addr = 32'hBFC0_0008;
      tick();
      chk("t req1", 32'(bus_req), 1);
      chk("t addr", bus_addr, 32'h8000_0010);
      tick();
      tick();
      tick();
      chk("t req4", 32'(bus_req), 1);
      chk("t err4", 32'(bus_err), 0);
      tick();
      chk("t err", 32'(bus_err), 1);
      chk("t dvalid", 32'(data_valid), 1);
      chk("t rdata0", data_rdata, 0);
      chk("t idle", 32'(bus_req), 0);
      data_req = 1'b0;
      tick();
      chk("t fgrant", 32'(bus_req), 1);
      chk("t faddr", bus_addr, 32'hBFC0_0008);
      chk("t err1", 32'(bus_err), 0);

      // Ack lands in the timeout cycle of the fetch
      tick();
      tick();
      tick();
      bus_ack   = 1'b1;
      bus_rdata = 32'h1234_5678;
      tick();
      bus_ack = 1'b0;
      chk("r ivalid", 32'(inst_valid), 1);
      chk("r rdata", inst_rdata, 32'h1234_5678);
      chk("r noerr", 32'(bus_err), 0);
      inst_req = 1'b0;
      tick();
      chk("r err1", 32'(bus_err), 0);

      // Reset in the middle of a fetch
      inst_req  = 1'b1;
      inst_addr = 32'hBFC0_000C;
      tick();
      chk("m req", 32'(bus_req), 1);
      rst = 1'b0;
      #1;
      chk("m req0", 32'(bus_req), 0);
      chk("m addr0", bus_addr, 0);
      chk("m valid0", 32'({inst_valid, data_valid}), 0);
      chk("m err0", 32'(bus_err), 0);
      chk("m perf0", perf_grant_cnt, 0);
      tick();
      chk("m held", 32'(bus_req), 0);
      rst = 1'b1;
      tick();
      chk("m regrant", 32'(bus_req), 1);
      chk("m readdr", bus_addr, 32'hBFC0_000C);
      bus_ack   = 1'b1;
      bus_rdata = 32'h0BAD_F00D;
      tick();
      bus_ack = 1'b0;
      chk("m valid", 32'(inst_valid), 1);
      chk("m rdata", inst_rdata, 32'h0BAD_F00D);
      inst_req = 1'b0;
      tick();
      chk("m end", 32'({bus_req, inst_valid, stall}), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
